// File: rtl/sargantana_icache_pkg.sv
// Shared constants and types for the Sargantana instruction cache.
package sargantana_icache_pkg;

  localparam int ICACHE_IDX_WIDTH = 6;
  localparam int ICACHE_N_WAY     = 4;
  localparam int WAY_W            = $clog2(ICACHE_N_WAY);

  typedef logic [ICACHE_IDX_WIDTH-1:0] idx_t;
  typedef logic [WAY_W-1:0]            way_t;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_COMPARE     = 3'd1,
    ST_MISS_REQ    = 3'd2,
    ST_REFILL_WAIT = 3'd3,
    ST_DRAIN       = 3'd4,
    ST_FLUSH       = 3'd5
  } ictrl_state_t;

endpackage

// File: rtl/sargantana_icache_ctrl_fsm_if.sv
// Core, L2 refill and array/replacement-unit signals of the icache control FSM.
interface sargantana_icache_ctrl_fsm_if;
  import sargantana_icache_pkg::*;

  // core request / response
  logic req_valid_i;
  idx_t req_idx_i;
  logic req_ready_o;
  logic kill_i;
  logic flush_i;
  logic resp_valid_o;
  logic busy_o;

  // arrays and replacement unit
  logic cache_hit_i;
  way_t way_to_replace_d_i;
  way_t way_to_replace_q_o;
  logic cache_rd_ena_o;
  logic cache_wr_ena_o;
  logic cmp_en_q_o;
  logic flush_ena_o;
  logic inval_o;
  idx_t cline_index_o;

  // L2 refill
  logic ifill_req_valid_o;
  logic ifill_req_ready_i;
  idx_t ifill_req_idx_o;
  logic ifill_resp_valid_i;

  // the control FSM
  modport slave (
    input  req_valid_i, req_idx_i, kill_i, flush_i, cache_hit_i,
           way_to_replace_d_i, ifill_req_ready_i, ifill_resp_valid_i,
    output req_ready_o, resp_valid_o, busy_o, way_to_replace_q_o,
           cache_rd_ena_o, cache_wr_ena_o, cmp_en_q_o, flush_ena_o,
           inval_o, cline_index_o, ifill_req_valid_o, ifill_req_idx_o
  );

  // the environment driving the FSM
  modport master (
    output req_valid_i, req_idx_i, kill_i, flush_i, cache_hit_i,
           way_to_replace_d_i, ifill_req_ready_i, ifill_resp_valid_i,
    input  req_ready_o, resp_valid_o, busy_o, way_to_replace_q_o,
           cache_rd_ena_o, cache_wr_ena_o, cmp_en_q_o, flush_ena_o,
           inval_o, cline_index_o, ifill_req_valid_o, ifill_req_idx_o
  );

endinterface

// File: rtl/sargantana_icache_ctrl_fsm.sv
// Instruction-cache control FSM: lookup, L2 refill, kill draining and full flush walk.
module sargantana_icache_ctrl_fsm
  import sargantana_icache_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rstn_i,
  sargantana_icache_ctrl_fsm_if.slave bus
);

  ictrl_state_t state_q, state_d;
  idx_t         idx_q, idx_d;
  idx_t         cnt_q, cnt_d;
  logic         flush_pend_q, flush_pend_d;
  way_t         way_to_replace_q;

  logic req_ready, rd_ena, wr_ena, cmp_en, flush_ena, inval, fill_valid, resp_valid;
  idx_t cline_index;

  // Next state and combinational control outputs from state and same-cycle inputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    req_ready    = 1'b0;
    rd_ena       = 1'b0;
    wr_ena       = 1'b0;
    cmp_en       = 1'b0;
    flush_ena    = 1'b0;
    inval        = 1'b0;
    fill_valid   = 1'b0;
    resp_valid   = 1'b0;
    cline_index  = idx_q;

    // A flush seen while busy is remembered and serviced from the next IDLE cycle.
    if (bus.flush_i && (state_q != ST_IDLE)) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.flush_i || flush_pend_q) begin
          state_d      = ST_FLUSH;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
        end else if (bus.req_valid_i) begin
          req_ready   = 1'b1;
          rd_ena      = 1'b1;
          idx_d       = bus.req_idx_i;
          cline_index = bus.req_idx_i;
          state_d     = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        cmp_en = 1'b1;
        if (bus.kill_i) begin
          state_d = ST_IDLE;
        end else if (bus.cache_hit_i) begin
          resp_valid = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        // A kill withdraws the request unless L2 accepts it in the same cycle.
        fill_valid = !bus.kill_i || bus.ifill_req_ready_i;
        if (bus.ifill_req_ready_i) begin
          state_d = bus.kill_i ? ST_DRAIN : ST_REFILL_WAIT;
        end else if (bus.kill_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_REFILL_WAIT: begin
        if (bus.ifill_resp_valid_i) begin
          wr_ena     = 1'b1;
          resp_valid = 1'b1;
          state_d    = ST_IDLE;
        end else if (bus.kill_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The outstanding refill is swallowed without touching the arrays.
        flush_ena = 1'b1;
        if (bus.ifill_resp_valid_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        inval       = 1'b1;
        cline_index = cnt_q;
        cnt_d       = cnt_q + idx_t'(1);
        if (&cnt_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched index, flush counter, pending flush and replacement-way registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      cnt_q            <= '0;
      flush_pend_q     <= 1'b0;
      way_to_replace_q <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      flush_pend_q     <= flush_pend_d;
      way_to_replace_q <= bus.way_to_replace_d_i;
    end
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign bus.req_ready_o        = rstn_i & req_ready;
  assign bus.cache_rd_ena_o     = rstn_i & rd_ena;
  assign bus.cache_wr_ena_o     = rstn_i & wr_ena;
  assign bus.cmp_en_q_o         = rstn_i & cmp_en;
  assign bus.flush_ena_o        = rstn_i & flush_ena;
  assign bus.inval_o            = rstn_i & inval;
  assign bus.ifill_req_valid_o  = rstn_i & fill_valid;
  assign bus.resp_valid_o       = rstn_i & resp_valid;
  assign bus.busy_o             = rstn_i & ((state_q != ST_IDLE) || flush_pend_q);
  assign bus.cline_index_o      = rstn_i ? cline_index : '0;
  assign bus.ifill_req_idx_o    = (rstn_i && fill_valid) ? idx_q : '0;
  assign bus.way_to_replace_q_o = way_to_replace_q;

endmodule

// File: tb/tb_sargantana_icache_ctrl_fsm.sv
// Scoreboard bench for the icache control FSM with a transaction-level expectation model.
module tb_sargantana_icache_ctrl_fsm;
  import sargantana_icache_pkg::*;

  localparam int LINES = 1 << ICACHE_IDX_WIDTH;
  localparam int EV_HIT = 0, EV_REFILL = 1, EV_FLUSH = 2;

  typedef struct {
    int kind;
    int idx;
    int way;
  } ev_t;

  logic clk;
  logic rstn;
  sargantana_icache_ctrl_fsm_if bus();

  sargantana_icache_ctrl_fsm dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  ev_t  evq[$];
  bit   exp_cmp = 0, exp_fill = 0, exp_drain = 0;
  int   exp_fill_idx = 0;
  int   frun = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares per-cycle control flags and pops the event queue on every response / flush end.
  always @(negedge clk) begin
    if (!rstn) begin
      frun = 0;
    end else begin
      chk("cmp_en", 32'(bus.cmp_en_q_o), 32'(exp_cmp));
      chk("ifill_valid", 32'(bus.ifill_req_valid_o), 32'(exp_fill));
      if (bus.ifill_req_valid_o) chk("ifill_idx", 32'(bus.ifill_req_idx_o), 32'(exp_fill_idx));
      chk("flush_ena", 32'(bus.flush_ena_o), 32'(exp_drain));
      if (bus.resp_valid_o) begin
        if (evq.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          ev_t e;
          e = evq.pop_front();
          chk("resp_kind_wr", 32'(bus.cache_wr_ena_o), 32'(e.kind == EV_REFILL));
          chk("resp_idx", 32'(bus.cline_index_o), 32'(e.idx));
          if (e.kind == EV_REFILL) chk("resp_way", 32'(bus.way_to_replace_q_o), 32'(e.way));
        end
      end else begin
        chk("wr_without_resp", 32'(bus.cache_wr_ena_o), 32'd0);
      end
      if (bus.inval_o) begin
        chk("flush_sweep_idx", 32'(bus.cline_index_o), 32'(frun));
        frun++;
      end else if (frun > 0) begin
        if (evq.size() == 0) begin
          fail_now("unexpected_flush");
        end else begin
          ev_t e;
          e = evq.pop_front();
          chk("flush_event", 32'(e.kind), 32'(EV_FLUSH));
          chk("flush_len", 32'(frun), 32'(LINES));
        end
        frun = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy_o && n < 4 * LINES) begin
      tick();
      n++;
    end
    if (bus.busy_o) fail_now("wait_idle");
  endtask

  task automatic do_flush();
    bus.flush_i = 1'b1;
    evq.push_back('{EV_FLUSH, 0, 0});
    tick();
    bus.flush_i = 1'b0;
    wait_idle();
    $display("txn flush");
  endtask

  // kmode: 0 none, 1 kill at compare, 2 kill before handshake, 3 kill with handshake,
  //        4 kill while waiting for refill, 5 kill together with the refill response
  task automatic do_req(input int idx, input bit hit, input int kmode, input int rdly,
                        input int sdly, input int way, input bit fl, output int waited);
    bit drain = 0;
    waited = 0;
    bus.req_valid_i = 1'b1;
    bus.req_idx_i   = idx_t'(idx);
    #1;
    while (!bus.req_ready_o && waited < 4 * LINES) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (!bus.req_ready_o) begin
      fail_now("req_accept");
      bus.req_valid_i = 1'b0;
      return;
    end
    chk("rd_ena_accept", 32'(bus.cache_rd_ena_o), 32'd1);
    chk("cline_accept", 32'(bus.cline_index_o), 32'(idx));
    tick();
    bus.req_valid_i        = 1'b0;
    bus.cache_hit_i        = hit;
    bus.way_to_replace_d_i = way_t'(way);
    bus.kill_i             = (kmode == 1);
    exp_cmp                = 1'b1;
    if (kmode == 1 || hit) begin
      if (kmode != 1) evq.push_back('{EV_HIT, idx, 0});
      tick();
      bus.kill_i = 1'b0; bus.cache_hit_i = 1'b0; exp_cmp = 1'b0;
    end else begin
      tick();
      exp_cmp = 1'b0; bus.cache_hit_i = 1'b0;
      exp_fill = 1'b1; exp_fill_idx = idx;
      bus.flush_i = fl;
      for (int i = 0; i < rdly; i++) begin
        tick();
        bus.flush_i = 1'b0;
      end
      if (kmode == 2) begin
        bus.kill_i = 1'b1; exp_fill = 1'b0;
        tick();
        bus.kill_i = 1'b0; bus.flush_i = 1'b0;
      end else begin
        bus.ifill_req_ready_i = 1'b1;
        bus.kill_i = (kmode == 3);
        tick();
        bus.ifill_req_ready_i = 1'b0; bus.kill_i = 1'b0; bus.flush_i = 1'b0; exp_fill = 1'b0;
        if (kmode == 3) begin
          drain = 1;
        end else begin
          for (int i = 0; i < sdly; i++) tick();
          if (kmode == 4) begin
            bus.kill_i = 1'b1;
            tick();
            bus.kill_i = 1'b0;
            drain = 1;
          end else begin
            bus.ifill_resp_valid_i = 1'b1;
            bus.kill_i = (kmode == 5);
            evq.push_back('{EV_REFILL, idx, way});
            tick();
            bus.ifill_resp_valid_i = 1'b0; bus.kill_i = 1'b0;
          end
        end
        if (drain) begin
          exp_drain = 1'b1;
          for (int i = 0; i < sdly; i++) tick();
          bus.ifill_resp_valid_i = 1'b1;
          tick();
          bus.ifill_resp_valid_i = 1'b0;
          exp_drain = 1'b0;
        end
      end
    end
    if (fl && !hit && kmode != 1) evq.push_back('{EV_FLUSH, 0, 0});
    $display("txn req idx=0x%0h hit=%0d kill=%0d way=%0d flush=%0d", idx, hit, kmode, way, fl);
  endtask

  initial begin
    int w;
    bus.req_valid_i = 1'b1; bus.req_idx_i = '1; bus.kill_i = 1'b0; bus.flush_i = 1'b0;
    bus.cache_hit_i = 1'b0; bus.way_to_replace_d_i = '0;
    bus.ifill_req_ready_i = 1'b0; bus.ifill_resp_valid_i = 1'b0;
    rstn = 1'b0;
    #2;
    chk("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_rd_ena", 32'(bus.cache_rd_ena_o), 32'd0);
    chk("rst_cline", 32'(bus.cline_index_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_way_q", 32'(bus.way_to_replace_q_o), 32'd0);
    repeat (2) tick();
    bus.req_valid_i = 1'b0;
    rstn = 1'b1;
    tick();

    // hit at 0x05
    do_req(32'h05, 1'b1, 0, 0, 0, 1, 1'b0, w);
    chk("hit_back_idle", 32'(bus.busy_o), 32'd0);
    // miss at 0x12, way 2, ready low 3 cycles, flush during MISS_REQ, then a pending request
    do_req(32'h12, 1'b0, 0, 3, 2, 2, 1'b1, w);
    do_req(32'h07, 1'b1, 0, 0, 0, 0, 1'b0, w);
    chk("flush_before_req_wait", 32'(w), 32'(LINES + 1));
    // kill during refill wait, response dropped
    do_req(32'h21, 1'b0, 4, 1, 2, 3, 1'b0, w);
    chk("drain_back_idle", 32'(bus.busy_o), 32'd0);
    // standalone flush
    wait_idle();
    do_flush();
    chk("flush_done_busy", 32'(bus.busy_o), 32'd0);

    for (int t = 0; t < 40; t++) begin
      int k;
      wait_idle();
      if ($urandom_range(0, 9) == 0) begin
        do_flush();
      end else begin
        k = $urandom_range(0, 9);
        do_req($urandom_range(0, LINES - 1), 1'($urandom_range(0, 1)), (k > 5) ? 0 : k,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, ICACHE_N_WAY - 1),
               ($urandom_range(0, 7) == 0), w);
      end
    end
    wait_idle();

    // reset while waiting for a refill, then a stray response
    bus.way_to_replace_d_i = 2'd3;
    bus.req_valid_i = 1'b1; bus.req_idx_i = idx_t'(8'h2A);
    #1;
    if (!bus.req_ready_o) fail_now("rst_test_accept");
    tick();
    bus.req_valid_i = 1'b0; bus.cache_hit_i = 1'b0; exp_cmp = 1'b1;
    tick();
    exp_cmp = 1'b0; exp_fill = 1'b1; exp_fill_idx = 32'h2A; bus.ifill_req_ready_i = 1'b1;
    tick();
    bus.ifill_req_ready_i = 1'b0; exp_fill = 1'b0;
    tick();
    chk("refill_wait_busy", 32'(bus.busy_o), 32'd1);
    rstn = 1'b0;
    #1;
    chk("async_rst_outputs",
        32'({bus.req_ready_o, bus.cache_rd_ena_o, bus.cache_wr_ena_o, bus.cmp_en_q_o,
             bus.flush_ena_o, bus.inval_o, bus.ifill_req_valid_o, bus.resp_valid_o, bus.busy_o,
             bus.cline_index_o, bus.ifill_req_idx_o}), 32'd0);
    chk("async_rst_way_q", 32'(bus.way_to_replace_q_o), 32'd0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    bus.ifill_resp_valid_i = 1'b1;
    #1;
    chk("stray_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("stray_wr_ena", 32'(bus.cache_wr_ena_o), 32'd0);
    tick();
    bus.ifill_resp_valid_i = 1'b0;
    chk("stray_busy", 32'(bus.busy_o), 32'd0);
    repeat (3) tick();
    chk("evq_empty", 32'(evq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
